// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-ported main_mem between fetch and data ports, data first.
// Defining MEM_ARB_STARVE_GUARD_EN lets fetch win after MAX_WAIT denied request cycles.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic [DATA_W-1:0] o_mem_wr_val,
  input  logic [DATA_W-1:0] i_mem_rd_val,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(MEM_LAT > 2 ? MEM_LAT : 2);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_data_q, own_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              access, resp, arb, if_prio, d_win;

  if (MEM_LAT < 1 || MAX_WAIT < 1) begin : g_param_check
    $error("mem_arbiter: MEM_LAT and MAX_WAIT must be >= 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  assign if_prio = wait_q == WAIT_W'(MAX_WAIT);
  assign wait_d  = (!i_if_req || o_if_gnt) ? '0 : if_prio ? wait_q : wait_q + 1'b1;
  always_ff @(posedge i_clk) wait_q <= !i_rst_n ? '0 : wait_d;
`else
  assign if_prio = 1'b0;
`endif

  assign access   = state_q == ACCESS;
  assign resp     = state_q == RESP;
  // RESP arbitrates like IDLE so a new grant overlaps the response cycle
  assign arb      = i_rst_n && !access;
  assign d_win    = i_d_req && !(if_prio && i_if_req);
  assign o_d_gnt  = arb && d_win;
  assign o_if_gnt = arb && i_if_req && !d_win;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_data_d = own_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    if (access) begin
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = RESP;
        rdata_d = we_q ? '0 : i_mem_rd_val;
      end
    end else if (o_d_gnt || o_if_gnt) begin
      state_d    = ACCESS;
      cnt_d      = CNT_W'(MEM_LAT - 1);
      own_data_d = o_d_gnt;
      we_d       = o_d_gnt && i_d_we;
      addr_d     = o_d_gnt ? i_d_addr : i_if_addr;
      wdata_d    = o_d_gnt ? i_d_wdata : '0;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_data_q <= own_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_busy       = access;
  assign o_mem_addr   = access ? addr_q : '0;
  assign o_mem_wr_en  = access && we_q && cnt_q == CNT_W'(MEM_LAT - 1);
  assign o_mem_wr_val = access ? wdata_q : '0;
  assign o_if_rvalid  = resp && !own_data_q;
  assign o_d_rvalid   = resp && own_data_q;
  assign o_if_rdata   = o_if_rvalid ? rdata_q : '0;
  assign o_d_rdata    = o_d_rvalid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a transaction-level scoreboard.
module tb_mem_arbiter;
  localparam int LAT = 3, MW = 2, N = 4096;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_if_req = 1'b0, i_d_req = 1'b0, i_d_we = 1'b0;
  logic [31:0] i_if_addr = '0, i_d_addr = '0, i_d_wdata = '0;
  logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_mem_wr_en, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wr_val, i_mem_rd_val;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_val(o_mem_wr_val),
    .i_mem_rd_val(i_mem_rd_val), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign i_mem_rd_val = mem_f(o_mem_addr);

  // per-cycle expected outputs, scheduled when a grant is predicted
  logic        e_busy [N];
  logic        e_wr   [N];
  logic        e_ifv  [N];
  logic        e_dv   [N];
  logic [31:0] e_addr [N];
  logic [31:0] e_wval [N];
  logic [31:0] e_rdata[N];
  int cyc = 0, busy_until = -1, wcnt = 0, tests = 0, fails = 0;
  logic g_if = 1'b0, g_d = 1'b0;

  task automatic clear_slot(input int t);
    e_busy[t] = 0; e_wr[t] = 0; e_ifv[t] = 0; e_dv[t] = 0;
    e_addr[t] = 0; e_wval[t] = 0; e_rdata[t] = 0;
  endtask

  // checks one cycle against the scoreboard, then advances to the next negedge
  task automatic step();
    logic xi, xd, prio, arb, sw;
    logic [31:0] a, w, eir, edr;
    int t;
    t = cyc;
    #1;
    prio = GUARD && (wcnt == MW);
    arb  = i_rst_n && (t > busy_until);
    xd   = arb && i_d_req && !(prio && i_if_req);
    xi   = arb && i_if_req && !xd;
    eir  = e_ifv[t] ? e_rdata[t] : 32'h0;
    edr  = e_dv[t] ? e_rdata[t] : 32'h0;
    tests += 11;
    if (o_d_gnt !== xd) begin fails++; $display("FAIL d_gnt cyc=%0d got=%b exp=%b", t, o_d_gnt, xd); end
    if (o_if_gnt !== xi) begin fails++; $display("FAIL if_gnt cyc=%0d got=%b exp=%b", t, o_if_gnt, xi); end
    if (o_busy !== e_busy[t]) begin fails++; $display("FAIL busy cyc=%0d got=%b exp=%b", t, o_busy, e_busy[t]); end
    if (o_mem_addr !== e_addr[t]) begin fails++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", t, o_mem_addr, e_addr[t]); end
    if (o_mem_wr_en !== e_wr[t]) begin fails++; $display("FAIL mem_wr_en cyc=%0d got=%b exp=%b", t, o_mem_wr_en, e_wr[t]); end
    if (o_mem_wr_val !== e_wval[t]) begin fails++; $display("FAIL mem_wr_val cyc=%0d got=%h exp=%h", t, o_mem_wr_val, e_wval[t]); end
    if (o_if_rvalid !== e_ifv[t]) begin fails++; $display("FAIL if_rvalid cyc=%0d got=%b exp=%b", t, o_if_rvalid, e_ifv[t]); end
    if (o_if_rdata !== eir) begin fails++; $display("FAIL if_rdata cyc=%0d got=%h exp=%h", t, o_if_rdata, eir); end
    if (o_d_rvalid !== e_dv[t]) begin fails++; $display("FAIL d_rvalid cyc=%0d got=%b exp=%b", t, o_d_rvalid, e_dv[t]); end
    if (o_d_rdata !== edr) begin fails++; $display("FAIL d_rdata cyc=%0d got=%h exp=%h", t, o_d_rdata, edr); end
    if (^{o_if_rdata, o_d_rdata, o_mem_addr} === 1'bx) begin fails++; $display("FAIL xcheck cyc=%0d got=x exp=known", t); end
    g_if = o_if_gnt;
    g_d  = o_d_gnt;
    if (!i_rst_n) begin
      for (int k = 1; k <= LAT + 1; k++) clear_slot(t + k);
      busy_until = -1;
      wcnt = 0;
    end else begin
      if (xi || xd) begin
        a  = xd ? i_d_addr : i_if_addr;
        w  = xd ? i_d_wdata : 32'h0;
        sw = xd && i_d_we;
        for (int k = 1; k <= LAT; k++) begin
          e_busy[t+k] = 1; e_addr[t+k] = a; e_wval[t+k] = w;
        end
        e_wr[t+1] = sw;
        e_ifv[t+LAT+1] = xi;
        e_dv[t+LAT+1] = xd;
        e_rdata[t+LAT+1] = sw ? 32'h0 : mem_f(a);
        busy_until = t + LAT;
      end
      wcnt = (i_if_req && !xi) ? ((wcnt < MW) ? wcnt + 1 : MW) : 0;
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic drain();
    i_if_req = 0; i_d_req = 0;
    repeat (LAT + 2) step();
  endtask

  task automatic test_reset();
    i_rst_n = 0; i_if_req = 1; i_d_req = 1; i_if_addr = 32'h4; i_d_addr = 32'h8;
    step(); step();
    tests++;
    if (g_if !== 0 || g_d !== 0) begin fails++; $display("FAIL reset_gnt got=%b%b exp=00", g_if, g_d); end
    i_rst_n = 1; i_if_req = 0; i_d_req = 0;
    repeat (5) step();
    tests++;
    if ({o_busy, o_if_rvalid, o_d_rvalid, o_mem_wr_en, o_mem_addr} !== '0) begin
      fails++; $display("FAIL idle_outputs got=%h exp=0", {o_busy, o_if_rvalid, o_d_rvalid, o_mem_wr_en, o_mem_addr});
    end
  endtask

  task automatic test_fetch();
    i_if_req = 1; i_if_addr = 32'h10;
    step();
    tests++;
    if (g_if !== 1) begin fails++; $display("FAIL fetch_gnt got=%b exp=1", g_if); end
    i_if_req = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tests += 3;
      if (o_if_rvalid !== (k == LAT + 1)) begin fails++; $display("FAIL fetch_rvalid k=%0d got=%b exp=%b", k, o_if_rvalid, k == LAT + 1); end
      if (o_if_rdata !== ((k == LAT + 1) ? 32'hDEADBEEF : 32'h0)) begin fails++; $display("FAIL fetch_rdata k=%0d got=%h", k, o_if_rdata); end
      if (o_mem_addr !== ((k <= LAT) ? 32'h10 : 32'h0)) begin fails++; $display("FAIL fetch_addr k=%0d got=%h", k, o_mem_addr); end
      step();
    end
  endtask

  task automatic test_store();
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h40; i_d_wdata = 32'h12345678;
    step();
    tests++;
    if (g_d !== 1) begin fails++; $display("FAIL store_gnt got=%b exp=1", g_d); end
    i_d_req = 0; i_d_we = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tests += 4;
      if (o_mem_wr_en !== (k == 1)) begin fails++; $display("FAIL store_wr_en k=%0d got=%b exp=%b", k, o_mem_wr_en, k == 1); end
      if (o_mem_addr !== ((k <= LAT) ? 32'h40 : 32'h0)) begin fails++; $display("FAIL store_addr k=%0d got=%h", k, o_mem_addr); end
      if (o_d_rvalid !== (k == LAT + 1)) begin fails++; $display("FAIL store_rvalid k=%0d got=%b exp=%b", k, o_d_rvalid, k == LAT + 1); end
      if (o_d_rdata !== 32'h0) begin fails++; $display("FAIL store_rdata k=%0d got=%h exp=0", k, o_d_rdata); end
      step();
    end
  endtask

  task automatic test_both();
    int gi, dr, ir;
    gi = -1; dr = -1; ir = -1;
    i_if_req = 1; i_if_addr = $urandom & 32'hFFF0; i_d_req = 1; i_d_we = 0; i_d_addr = $urandom;
    step();
    tests++;
    if (g_d !== 1 || g_if !== 0) begin fails++; $display("FAIL both_first got=%b%b exp=10", g_d, g_if); end
    i_d_req = 0;
    for (int r = 1; r <= 2 * LAT + 4; r++) begin
      if (o_d_rvalid === 1'b1) dr = r;
      if (o_if_rvalid === 1'b1) ir = r;
      step();
      if (g_if) begin gi = r; i_if_req = 0; end
    end
    tests += 2;
    if (gi !== LAT + 1) begin fails++; $display("FAIL both_fetch_gnt got=%0d exp=%0d", gi, LAT + 1); end
    if (ir - dr !== LAT + 1) begin fails++; $display("FAIL both_spacing got=%0d exp=%0d", ir - dr, LAT + 1); end
  endtask

  task automatic test_starve();
    int nif, nd;
    nif = 0; nd = 0;
    i_d_req = 1; i_d_we = 0; i_d_addr = $urandom; i_if_req = 1; i_if_addr = $urandom;
    repeat (20) begin
      step();
      if (g_d) begin nd++; i_d_addr = $urandom; i_d_we = $urandom_range(0, 1); i_d_wdata = $urandom; end
      if (g_if) begin nif++; i_if_addr = $urandom; end
    end
    tests += 2;
    if ((nif > 0) !== GUARD) begin fails++; $display("FAIL starve_fetch got=%0d grants exp_any=%b", nif, GUARD); end
    if (nd == 0) begin fails++; $display("FAIL starve_data got=0 exp>0"); end
  endtask

  task automatic test_rst_mid();
    int ndv;
    ndv = 0;
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h123;
    step();
    i_d_req = 0; i_if_req = 1; i_if_addr = 32'h200;
    step();
    i_rst_n = 0;
    step();
    i_rst_n = 1;
    step();
    tests++;
    if (g_if !== 1) begin fails++; $display("FAIL rst_mid_fetch_gnt got=%b exp=1", g_if); end
    i_if_req = 0;
    repeat (LAT + 3) begin
      if (o_d_rvalid === 1'b1) ndv++;
      step();
    end
    tests++;
    if (ndv !== 0) begin fails++; $display("FAIL rst_mid_rvalid got=%0d exp=0", ndv); end
  endtask

  task automatic test_random();
    g_if = 0; g_d = 0;
    repeat (1500) begin
      if (g_if || !i_if_req) begin i_if_req = $urandom_range(0, 1); i_if_addr = $urandom; end
      else if ($urandom_range(0, 15) == 0) i_if_req = 0;
      if (g_d || !i_d_req) begin
        i_d_req = $urandom_range(0, 2) == 0; i_d_we = $urandom_range(0, 1);
        i_d_addr = $urandom; i_d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) i_d_req = 0;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) clear_slot(i);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    test_reset();
    test_fetch();   drain();
    test_store();   drain();
    test_both();    drain();
    test_starve();  drain();
    test_rst_mid(); drain();
    test_random();  drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
